// File: rtl/mdu_seq_if.sv
// Pipeline-facing bundle of the multiply/divide sequencer: request, cancel,
// handshake status and the HI/LO result registers.
interface mdu_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             divzero;

  modport master (output start, op, a, b, abort, input busy, done, hi, lo, divzero);
  modport slave  (input start, op, a, b, abort, output busy, done, hi, lo, divzero);
endinterface

// File: rtl/mdu_seq.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Optional MDU_EARLY_OUT_EN: multiplies stop once the remaining multiplier bits are zero.
module mdu_seq #(parameter int WIDTH = 32) (
  input  logic      ph1,
  input  logic      reset,
  mdu_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]      count;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r, addend, hi_r, lo_r;
  logic [2*WIDTH-1:0] acc, acc_step, prod, prod_fix, res;
  logic               neg_p, neg_r, divzero_r;
  logic               is_div, is_signed, iter_end;
  logic [WIDTH-1:0]   a_abs, b_abs, q_fix, r_fix;

  assign is_div    = op_r[1];
  assign is_signed = ~op_r[0];
  assign a_abs     = (is_signed && a_r[WIDTH-1]) ? -a_r : a_r;
  assign b_abs     = (is_signed && b_r[WIDTH-1]) ? -b_r : b_r;

  // Shared WIDTH+1 bit adder: shift-add for multiply, trial subtract for divide.
  // The extra bit holds the remainder bit shifted out of the top during divide.
  logic [WIDTH:0]   add_x, add_y;
  logic             add_cin;
  logic [WIDTH+1:0] add_sum;

  always_comb begin
    add_x   = {1'b0, acc[2*WIDTH-1:WIDTH]};
    add_y   = {1'b0, (acc[0] ? addend : {WIDTH{1'b0}})};
    add_cin = 1'b0;
    if (is_div) begin
      add_x   = acc[2*WIDTH-1:WIDTH-1];
      add_y   = ~{1'b0, addend};
      add_cin = 1'b1;
    end
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};

  // Divide: carry-out set means no borrow, so keep the difference and shift in a 1.
  always_comb begin
    if (is_div)
      acc_step = add_sum[WIDTH+1] ? {add_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                                  : {acc[2*WIDTH-2:0], 1'b0};
    else
      acc_step = {add_sum[WIDTH:0], acc[WIDTH-1:1]};
  end

`ifdef MDU_EARLY_OUT_EN
  logic [CW-1:0] cnt_nxt;
  assign cnt_nxt  = count + 1'b1;
  assign iter_end = (count == CW'(WIDTH-1)) ||
                    (!is_div && ((acc_step[WIDTH-1:0] & ({WIDTH{1'b1}} >> cnt_nxt)) == '0));
  // Skipped iterations would only have shifted right; realign the product here.
  assign prod     = acc >> (CW'(WIDTH) - count);
`else
  assign iter_end = (count == CW'(WIDTH-1));
  assign prod     = acc;
`endif

  assign prod_fix = neg_p ? -prod : prod;
  assign q_fix    = neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign res      = is_div ? {r_fix, q_fix} : prod_fix;

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort) state_nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE: if (bus.start) state_nxt = S_PREP;
        S_PREP: state_nxt = (is_div && b_r == '0) ? S_DONE : S_ITER;
        S_ITER: if (iter_end) state_nxt = S_FIX;
        S_FIX:  state_nxt = S_DONE;
        S_DONE: state_nxt = bus.start ? S_PREP : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy = (state == S_PREP) || (state == S_ITER) || (state == S_FIX);
    bus.done = (state == S_DONE);
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      count     <= '0;
      op_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      addend    <= '0;
      acc       <= '0;
      neg_p     <= 1'b0;
      neg_r     <= 1'b0;
      hi_r      <= '0;
      lo_r      <= '0;
      divzero_r <= 1'b0;
    end else if (!bus.abort) begin
      case (state)
        S_IDLE, S_DONE: if (bus.start) begin
          op_r      <= bus.op;
          a_r       <= bus.a;
          b_r       <= bus.b;
          divzero_r <= 1'b0;
        end
        S_PREP: begin
          if (is_div && b_r == '0) begin
            divzero_r <= 1'b1;
            hi_r      <= a_r;
            lo_r      <= '1;
          end else begin
            count  <= '0;
            neg_p  <= is_signed & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
            neg_r  <= is_signed & a_r[WIDTH-1];
            addend <= is_div ? b_abs : a_abs;
            acc    <= {{WIDTH{1'b0}}, (is_div ? a_abs : b_abs)};
          end
        end
        S_ITER: begin
          acc   <= acc_step;
          count <= count + 1'b1;
        end
        S_FIX: begin
          hi_r <= res[2*WIDTH-1:WIDTH];
          lo_r <= res[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.hi      = hi_r;
  assign bus.lo      = lo_r;
  assign bus.divzero = divzero_r;
endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: directed corner cases plus random ops against an arithmetic model.
module tb_mdu_seq;
  logic ph1, reset;
  int n_cmp, n_err;
  logic [31:0] prev_hi, prev_lo;
  logic        prev_dz;

  mdu_seq_if #(.WIDTH(32)) intf();
  mdu_seq #(.WIDTH(32)) dut (.ph1(ph1), .reset(reset), .bus(intf.slave));

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el,
                                output logic edz, output int lat);
    longint sa, sb;
    logic [63:0] t;
    logic [31:0] m;
    int k;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    edz = 1'b0;
    lat = 34;
    t = '0;
    case (op)
      2'b00: begin t = sa * sb; eh = t[63:32]; el = t[31:0]; end
      2'b01: begin t = {32'h0, a} * {32'h0, b}; eh = t[63:32]; el = t[31:0]; end
      2'b10: begin
        if (b == 0) begin edz = 1'b1; eh = a; el = 32'hFFFF_FFFF; lat = 1; end
        else begin t = sa / sb; el = t[31:0]; t = sa % sb; eh = t[31:0]; end
      end
      default: begin
        if (b == 0) begin edz = 1'b1; eh = a; el = 32'hFFFF_FFFF; lat = 1; end
        else begin el = a / b; eh = a % b; end
      end
    endcase
`ifdef MDU_EARLY_OUT_EN
    if (!op[1]) begin
      m = (op == 2'b00 && b[31]) ? -b : b;
      k = 1;
      for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
      lat = k + 2;
    end
`else
    m = '0;
    k = 0;
`endif
  endfunction

  // Called at a negedge; the following posedge is edge 0.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    intf.start = 1'b1; intf.op = op; intf.a = a; intf.b = b;
    @(negedge ph1);
    intf.start = 1'b0;
  endtask

  // Entered at the negedge after edge n0; returns at the negedge of the DONE cycle.
  task automatic finish_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int n0, input string tag);
    logic [31:0] eh, el;
    logic edz;
    int lat, n, busy_bad;
    model(op, a, b, eh, el, edz, lat);
    chk({tag, "_busy0"}, 64'(intf.busy), 64'd1);
    chk({tag, "_dzclr"}, 64'(intf.divzero), 64'd0);
    n = n0;
    busy_bad = 0;
    while (n < 200) begin
      @(negedge ph1);
      n++;
      if (intf.done) break;
      if (!intf.busy) busy_bad++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_busyrun"}, 64'(busy_bad), 64'd0);
    chk({tag, "_hi"}, 64'(intf.hi), 64'(eh));
    chk({tag, "_lo"}, 64'(intf.lo), 64'(el));
    chk({tag, "_dz"}, 64'(intf.divzero), 64'(edz));
    chk({tag, "_busyd"}, 64'(intf.busy), 64'd0);
    prev_hi = eh; prev_lo = el; prev_dz = edz;
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input string tag);
    @(negedge ph1);
    issue(op, a, b);
    finish_op(op, a, b, 0, tag);
    @(negedge ph1);
    chk({tag, "_done1"}, 64'(intf.done), 64'd0);
  endtask

  initial begin
    int dcnt;
    logic [1:0] rop;
    logic [31:0] ra, rb;
    n_cmp = 0; n_err = 0;
    intf.start = 1'b0; intf.op = 2'b00; intf.a = '0; intf.b = '0; intf.abort = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge ph1);
    chk("rst_state", {intf.hi, intf.lo}, 64'd0);
    chk("rst_flags", {61'd0, intf.busy, intf.done, intf.divzero}, 64'd0);
    reset = 1'b0;

    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "mult_minneg");
    run(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run(2'b11, 32'd100, 32'd7, "divu");
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run(2'b10, 32'd9, 32'hFFFF_FFFC, "div_negb");
    run(2'b01, 32'd5, 32'd1, "multu_small");
    run(2'b11, 32'h1234, 32'd0, "divzero");
    run(2'b01, 32'd3, 32'd4, "dz_clear");

    // start while busy is ignored
    @(negedge ph1);
    issue(2'b11, 32'd100, 32'd7);
    repeat (4) @(negedge ph1);
    intf.start = 1'b1; intf.op = 2'b00; intf.a = 32'hDEAD; intf.b = 32'hBEEF;
    @(negedge ph1);
    intf.start = 1'b0;
    finish_op(2'b11, 32'd100, 32'd7, 5, "busy_start");

    // back-to-back start in the DONE cycle
    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    finish_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, "b2b");

    // abort with start at edge 10
    @(negedge ph1);
    issue(2'b01, 32'hFFFF_FFFF, 32'h1234_5678);
    repeat (9) @(negedge ph1);
    intf.abort = 1'b1; intf.start = 1'b1; intf.op = 2'b11; intf.a = 32'd50; intf.b = 32'd3;
    @(negedge ph1);
    intf.abort = 1'b0; intf.start = 1'b0;
    chk("abort_busy", 64'(intf.busy), 64'd0);
    dcnt = 0;
    repeat (40) begin @(negedge ph1); if (intf.done || intf.busy) dcnt++; end
    chk("abort_idle", 64'(dcnt), 64'd0);
    chk("abort_hilo", {intf.hi, intf.lo}, {prev_hi, prev_lo});
    chk("abort_dz", 64'(intf.divzero), 64'(prev_dz));

    // async reset mid-divide
    @(negedge ph1);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    repeat (19) @(negedge ph1);
    @(posedge ph1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_hilo", {intf.hi, intf.lo}, 64'd0);
    chk("rst_mid_flags", {61'd0, intf.busy, intf.done, intf.divzero}, 64'd0);
    @(negedge ph1);
    reset = 1'b0;
    run(2'b11, 32'd100, 32'd7, "post_rst");

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run(rop, ra, rb, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
